// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that streams multi-byte messages from N_REQ requesters
// into one UART transmitter, one byte per start/busy handshake.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int START_TMO = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] data_i,
  input  logic [N_REQ-1:0]   last_i,
  input  logic               busy_i,
  output logic               start_o,
  output logic [7:0]         data_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [N_REQ-1:0]   ack_o,
  output logic               err_o
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = $clog2(START_TMO + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    LOAD     = 3'd2,
    START_TX = 3'd3,
    TX       = 3'd4,
    RELEASE  = 3'd5
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             pick_found;
  logic             last_flag;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       byte_arr [N_REQ];
  int               cand;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign byte_arr[gi] = data_i[8*gi +: 8];
    end
  endgenerate

  // Search starts one past the last released owner, so it gets lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (int'(rr_ptr) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      start_o   <= 1'b0;
      data_o    <= 8'h00;
      grant_o   <= '0;
      ack_o     <= '0;
      err_o     <= 1'b0;
      tmo_cnt   <= '0;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      owner     <= '0;
      last_flag <= 1'b0;
    end else begin
      ack_o <= '0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) state <= ARB;
        end
        ARB: begin
          if (pick_found) begin
            owner   <= pick_idx;
            grant_o <= N_REQ'(1) << pick_idx;
            state   <= LOAD;
          end else begin
            grant_o <= '0;
            state   <= IDLE;
          end
        end
        LOAD: begin
          data_o    <= byte_arr[owner];
          last_flag <= last_i[owner];
          ack_o     <= grant_o;
          start_o   <= ~busy_i;
          tmo_cnt   <= '0;
          state     <= START_TX;
        end
        START_TX: begin
          // Busy only counts as the UART's answer once start has been presented.
          if (start_o && busy_i) begin
            start_o <= 1'b0;
            state   <= TX;
          end else if (tmo_cnt == TMO_W'(START_TMO - 1)) begin
            start_o <= 1'b0;
            err_o   <= 1'b1;
            state   <= RELEASE;
          end else begin
            start_o <= ~busy_i;
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        TX: begin
          if (!busy_i) begin
            if (last_flag || !req_i[owner]) state <= RELEASE;
            else                            state <= LOAD;
          end
        end
        RELEASE: begin
          grant_o <= '0;
          rr_ptr  <= owner;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          start_o <= 1'b0;
          grant_o <= '0;
        end
      endcase
    end
  end

endmodule
